// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the pipeline inter-stage registers.
//  skid_state_e : handshake state of a pipe_skid_stage instance
//  dmem_wb_t    : packed dmem/wb stage payload (DMEM_WB_W bits)
//  state_occ()  : number of held entries encoded by a state
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [63:0] csrval;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] result;
    logic [31:0] instrId;
    logic [63:0] memdata;
    logic [63:0] rs1val;
    logic [63:0] rs2val;
    logic        regw;
    logic        memw;
    logic        memr;
    logic        branch;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } dmem_wb_t;

  localparam int unsigned DMEM_WB_W = $bits(dmem_wb_t);

  function automatic logic [1:0] state_occ(input skid_state_e s);
    case (s)
      EMPTY:   return 2'd0;
      HALF:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//  clk, rst : clock and synchronous reset
//  inc      : count one event this cycle
//  count    : current value, sticks at all-ones (CNT_W >= 2)
module pipe_skid_stage_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count events, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake.
//  MODE=1: main + skid entry, in_ready comes straight from flops.
//  MODE=0: single entry, in_ready = out_ready | !out_valid.
// Ports:
//  clk, rst             clock, synchronous active-high reset
//  flush                drop all held entries (payload contents kept)
//  in_valid/in_ready    upstream handshake, in_data payload
//  out_valid/out_ready  downstream handshake, out_data = main entry
//  occupancy            held entries (0..2)
//  stall_cnt            saturating count of out_valid & !out_ready cycles
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned       DATA_W  = 439,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter int unsigned       MODE    = 1,
  parameter int unsigned       CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_live;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_main_from_skid;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // r_live keeps in_ready low during reset and for the edge rst falls on,
  // without routing rst combinationally to in_ready.
  generate
    if (MODE == 32'd0) begin : g_single
      assign w_in_ready = r_live & (out_ready | ~w_out_valid);
    end else begin : g_skid
      assign w_in_ready = r_live & (r_state != FULL);
    end
  endgenerate

  // Acceptance enable: low in reset, high from the first edge after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Next state and payload steering. MODE=0 never reaches FULL because
  // in_ready already requires the main entry to drain in the same cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_load_main = 1'b1;
            w_state_nxt = HALF;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
            w_state_nxt = HALF;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = HALF;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_main_from_skid = 1'b1;
            w_state_nxt      = HALF;
          end else begin
            w_state_nxt = FULL;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main entry: drives out_data directly, refilled from input or skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= RST_VAL;
    end else if (w_load_main) begin
      r_main <= in_data;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end else begin
      r_main <= r_main;
    end
  end

  // Skid entry: catches the payload accepted while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid <= RST_VAL;
    end else if (w_load_skid) begin
      r_skid <= in_data;
    end else begin
      r_skid <= r_skid;
    end
  end

  pipe_skid_stage_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_out_valid & ~out_ready),
    .count (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign occupancy = state_occ(r_state);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: one skid-mode instance (A) and one single-register
// instance with a 4-bit stall counter (B). Directed checks run in the main
// process; per-instance monitors pop a FIFO scoreboard on every out_fire.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [15:0] a_in_data = 16'h0000;
  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_occ;
  logic [31:0] a_stall;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [15:0] b_in_data = 16'h0000;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  int checks = 0;
  int errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(16), .RST_VAL(16'hA5A5), .MODE(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_skid_stage #(.DATA_W(16), .RST_VAL(16'h0000), .MODE(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for A: deliver first, then flush drops, else accept.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_out: got %0h expected none", a_out_data);
        end else begin
          chk("a_out_data", {16'h0000, a_out_data}, {16'h0000, qa.pop_front()});
        end
      end
      if (a_flush) qa.delete();
      else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
    end
  end

  // Scoreboard for B.
  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_out: got %0h expected none", b_out_data);
        end else begin
          chk("b_out_data", {16'h0000, b_out_data}, {16'h0000, qb.pop_front()});
        end
      end
      if (b_flush) qb.delete();
      else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    end
  end

  initial begin
    // Reset with upstream pushing.
    a_in_valid = 1'b1; a_in_data = 16'h1111;
    b_in_valid = 1'b1; b_in_data = 16'h2222;
    step(); step();
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("rst_a_out_data", {16'h0000, a_out_data}, 32'h0000A5A5);
    chk("rst_a_stall", a_stall, 32'd0);
    chk("rst_a_occ", {30'd0, a_occ}, 32'd0);
    chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("rst_fall_a_in_ready_low", {31'd0, a_in_ready}, 32'd0);
    chk("rst_fall_b_in_ready_low", {31'd0, b_in_ready}, 32'd0);
    step();
    chk("post_rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("post_rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);

    // Streaming 1..8 with 1-cycle latency.
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'(i);
      step();
      chk("stream_out_data", {16'h0000, a_out_data}, i);
      chk("stream_occ", {30'd0, a_occ}, 32'd1);
    end
    a_in_valid = 1'b0;
    step();
    chk("stream_drain_occ", {30'd0, a_occ}, 32'd0);
    chk("stream_stall", a_stall, 32'd0);

    // Backpressure: A, B held; then drained in order.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h00A1;
    step();
    a_in_data = 16'h00B2;
    step();
    chk("bp_occ_full", {30'd0, a_occ}, 32'd2);
    chk("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
    chk("bp_stall_1", a_stall, 32'd1);
    a_in_valid = 1'b0;
    step();
    chk("bp_stall_2", a_stall, 32'd2);
    chk("bp_head", {16'h0000, a_out_data}, 32'h000000A1);
    a_out_ready = 1'b1;
    step();
    chk("bp_in_ready_back", {31'd0, a_in_ready}, 32'd1);
    chk("bp_second", {16'h0000, a_out_data}, 32'h000000B2);
    chk("bp_occ_half", {30'd0, a_occ}, 32'd1);
    step();
    chk("bp_occ_empty", {30'd0, a_occ}, 32'd0);
    chk("bp_stall_final", a_stall, 32'd2);

    // Flush while FULL with C offered in the flush cycle.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h0C01;
    step();
    a_in_data = 16'h0C02;
    step();
    a_flush = 1'b1; a_in_data = 16'h0CCC;
    step();
    chk("flush_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush_occ", {30'd0, a_occ}, 32'd0);
    chk("flush_payload_kept", {16'h0000, a_out_data}, 32'h00000C01);
    chk("flush_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    step(); step(); step();
    chk("flush_no_c", {31'd0, a_out_valid}, 32'd0);
    // Flush coinciding with delivery of D.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h0D0D;
    step();
    a_in_valid = 1'b0; a_flush = 1'b1; a_out_ready = 1'b1;
    step();
    a_flush = 1'b0;
    chk("flush_deliver_occ", {30'd0, a_occ}, 32'd0);
    chk("flush_stall", a_stall, 32'd4);

    // MODE=0: held A blocks input; consume A and accept B in one cycle.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h0A0A;
    step();
    b_in_valid = 1'b0;
    #1;
    chk("m0_in_ready_blocked", {31'd0, b_in_ready}, 32'd0);
    chk("m0_occ", {30'd0, b_occ}, 32'd1);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 16'h0B0B;
    #1;
    chk("m0_in_ready_comb", {31'd0, b_in_ready}, 32'd1);
    step();
    chk("m0_b_presented", {16'h0000, b_out_data}, 32'h00000B0B);
    chk("m0_b_valid", {31'd0, b_out_valid}, 32'd1);
    b_in_valid = 1'b0;
    step();
    chk("m0_empty", {30'd0, b_occ}, 32'd0);

    // Stall counter saturation on the 4-bit instance.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h5555;
    step();
    b_in_valid = 1'b0;
    chk("sat_start", {28'd0, b_stall}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) chk("sat_14", {28'd0, b_stall}, 32'd14);
    end
    chk("sat_hold", {28'd0, b_stall}, 32'd15);
    b_out_ready = 1'b1;
    step();

    // Random traffic on both instances against the FIFO scoreboards.
    for (int n = 0; n < 400; n++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = 16'($urandom_range(0, 65535));
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 24) == 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 16'($urandom_range(0, 65535));
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    step(); step(); step(); step();
    chk("rand_a_drained", qa.size(), 32'd0);
    chk("rand_b_drained", qb.size(), 32'd0);
    chk("rand_a_idle", {31'd0, a_out_valid}, 32'd0);
    chk("rand_b_idle", {31'd0, b_out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
